// File: rtl/approximate_multiplier_ext.sv
// approximate_multiplier_ext: sequential approximate multiplier that keeps n_effective significant bits per operand
module approximate_multiplier_ext #(
    parameter int n_input = 16,
    parameter int n_effective = 8,
    localparam int SW = $clog2(2*n_input+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Start,
    input  logic                     signed_mode,
    input  logic                     round_mode,
    input  logic [n_input-1:0]       pin1,
    input  logic [n_input-1:0]       pin2,
    output logic                     Busy,
    output logic                     Done,
    output logic [2*n_effective-1:0] pout,
    output logic [SW-1:0]            pshift,
    output logic                     psign
);
    localparam int NE = n_effective;
    localparam int PW = 2*n_effective;
    localparam int CW = $clog2(n_effective+1);
    localparam logic [n_input:0] LIM = (n_input+1)'(1) << n_effective;
    localparam logic [n_input-1:0] HALF = n_input'(1) << (n_effective-1);
    localparam logic [2:0] IDLE = 3'd0, NORM = 3'd1, ROUND = 3'd2, MULT = 3'd3, FIN = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [n_input-1:0] a_q, a_d, b_q, b_d;
    logic [SW-1:0]      k1_q, k1_d, k2_q, k2_d, pshift_q, pshift_d;
    logic               r1_q, r1_d, r2_q, r2_d, rm_q, rm_d, sg_q, sg_d, psign_q, psign_d;
    logic [PW-1:0]      acc_q, acc_d, pout_q, pout_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               need1, need2;
    logic [n_input:0]   inc1, inc2;
    logic [n_input-1:0] mag1, mag2;
    logic [PW-1:0]      a_ext, acc_n;

    assign need1 = {1'b0, a_q} >= LIM;
    assign need2 = {1'b0, b_q} >= LIM;
    assign inc1  = {1'b0, a_q} + (n_input+1)'(1);
    assign inc2  = {1'b0, b_q} + (n_input+1)'(1);
    // Two's complement magnitude; the most negative value maps to 2^(n_input-1) unchanged
    assign mag1  = (signed_mode && pin1[n_input-1]) ? -pin1 : pin1;
    assign mag2  = (signed_mode && pin2[n_input-1]) ? -pin2 : pin2;
    assign a_ext = {{NE{1'b0}}, a_q[NE-1:0]} << cnt_q;
    assign acc_n = acc_q + (b_q[0] ? a_ext : '0);

    // Next-state logic: capture, normalise, round, shift-add multiply, publish
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k1_d     = k1_q;
        k2_d     = k2_q;
        r1_d     = r1_q;
        r2_d     = r2_q;
        rm_d     = rm_q;
        sg_d     = sg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        pout_d   = pout_q;
        pshift_d = pshift_q;
        psign_d  = psign_q;
        case (state_q)
            IDLE: if (Start) begin
                a_d     = mag1;
                b_d     = mag2;
                sg_d    = signed_mode & (pin1[n_input-1] ^ pin2[n_input-1]);
                rm_d    = round_mode;
                k1_d    = '0;
                k2_d    = '0;
                r1_d    = 1'b0;
                r2_d    = 1'b0;
                state_d = NORM;
            end
            NORM: begin
                if (need1) begin
                    a_d  = a_q >> 1;
                    k1_d = k1_q + SW'(1);
                    r1_d = a_q[0];
                end
                if (need2) begin
                    b_d  = b_q >> 1;
                    k2_d = k2_q + SW'(1);
                    r2_d = b_q[0];
                end
                state_d = (!need1 && !need2) ? ROUND : NORM;
            end
            ROUND: begin
                if (rm_q && r1_q) begin
                    a_d  = (inc1 == LIM) ? HALF : inc1[n_input-1:0];
                    k1_d = (inc1 == LIM) ? k1_q + SW'(1) : k1_q;
                end
                if (rm_q && r2_q) begin
                    b_d  = (inc2 == LIM) ? HALF : inc2[n_input-1:0];
                    k2_d = (inc2 == LIM) ? k2_q + SW'(1) : k2_q;
                end
                acc_d   = '0;
                cnt_d   = '0;
                state_d = MULT;
            end
            MULT: begin
                acc_d = acc_n;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NE-1)) begin
                    pout_d   = acc_n;
                    pshift_d = k1_q + k2_q;
                    psign_d  = sg_q && (acc_n != '0);
                    state_d  = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k1_q     <= '0;
            k2_q     <= '0;
            r1_q     <= 1'b0;
            r2_q     <= 1'b0;
            rm_q     <= 1'b0;
            sg_q     <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            pout_q   <= '0;
            pshift_q <= '0;
            psign_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k1_q     <= k1_d;
            k2_q     <= k2_d;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            rm_q     <= rm_d;
            sg_q     <= sg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            pout_q   <= pout_d;
            pshift_q <= pshift_d;
            psign_q  <= psign_d;
        end
    end

    assign Busy   = state_q != IDLE;
    assign Done   = state_q == FIN;
    assign pout   = pout_q;
    assign pshift = pshift_q;
    assign psign  = psign_q;
endmodule

// File: tb/tb_approximate_multiplier_ext.sv
// tb_approximate_multiplier_ext: scoreboard bench with directed and randomized operations
module tb_approximate_multiplier_ext;
    localparam int N = 16, NE = 8, SW = $clog2(2*N+1);

    logic          clk = 1'b0, rst = 1'b1, Start = 1'b0, signed_mode = 1'b0, round_mode = 1'b0;
    logic [N-1:0]  pin1 = '0, pin2 = '0;
    logic          Busy, Done, psign;
    logic [2*NE-1:0] pout;
    logic [SW-1:0] pshift;

    approximate_multiplier_ext #(.n_input(N), .n_effective(NE)) dut (
        .clk(clk), .rst(rst), .Start(Start), .signed_mode(signed_mode), .round_mode(round_mode),
        .pin1(pin1), .pin2(pin2), .Busy(Busy), .Done(Done), .pout(pout), .pshift(pshift), .psign(psign)
    );

    always #5 clk = ~clk;

    typedef struct { int p; int s; int g; int c; } exp_t;
    exp_t q[$];
    int cyc = 0, errors = 0, checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: keep the top NE significant bits of each magnitude, optional round, exact product
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input bit sm, input bit rm, input int c);
        exp_t e;
        int m[2], k[2], v[2], r[2];
        m[0] = (sm && a[N-1]) ? (1 << N) - int'(a) : int'(a);
        m[1] = (sm && b[N-1]) ? (1 << N) - int'(b) : int'(b);
        for (int i = 0; i < 2; i++) begin
            k[i] = ($clog2(m[i] + 1) > NE) ? $clog2(m[i] + 1) - NE : 0;
            v[i] = m[i] >> k[i];
            r[i] = (k[i] > 0) ? (m[i] >> (k[i] - 1)) & 1 : 0;
        end
        e.c = c + 1 + ((k[0] > k[1]) ? k[0] : k[1]) + NE + 2;
        for (int i = 0; i < 2; i++)
            if (rm && r[i] == 1) begin
                v[i]++;
                if (v[i] == (1 << NE)) begin
                    v[i] = 1 << (NE - 1);
                    k[i]++;
                end
            end
        e.p = v[0] * v[1];
        e.s = k[0] + k[1];
        e.g = (sm && (a[N-1] ^ b[N-1]) && e.p != 0) ? 1 : 0;
        return e;
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && Done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.c);
                chk("pout", pout, e.p);
                chk("pshift", pshift, e.s);
                chk("psign", psign, e.g);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (Busy && t < 100);
        if (Busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit sm, input bit rm,
                         input int ep, input int es, input int eg, input int lat);
        exp_t e;
        wait_idle();
        pin1 = a; pin2 = b; signed_mode = sm; round_mode = rm; Start = 1'b1;
        e.p = ep; e.s = es; e.g = eg; e.c = cyc + 1 + lat;
        q.push_back(e);
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pout"}, pout, 0);
        chk({nm, "_pshift"}, pshift, 0);
        chk({nm, "_psign"}, psign, 0);
        chk({nm, "_busy"}, Busy, 0);
        chk({nm, "_done"}, Done, 0);
    endtask

    initial begin
        exp_t e;
        int t;
        #1 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(16'd200, 16'd100, 0, 0, 20000, 0, 0, 10);
        issue(16'hFFFF, 16'd3, 0, 0, 765, 8, 0, 18);
        issue(16'hFFFF, 16'd3, 0, 1, 384, 9, 0, 18);
        issue(16'hFFFE, 16'h0005, 1, 0, 10, 0, 1, 10);
        issue(16'h8000, 16'h0001, 1, 0, 128, 8, 1, 18);
        issue(16'h0000, 16'hFFFF, 1, 0, 0, 0, 0, 10);
        issue(16'd200, 16'd100, 0, 0, 20000, 0, 0, 10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            Start = ~Start;
            pin1 = 16'($urandom);
            pin2 = 16'($urandom);
        end
        issue(16'hFFFF, 16'd3, 0, 0, 765, 8, 0, 18);
        repeat (11) @(posedge clk);
        #3 rst = 1'b1;
        q.delete();
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        pin1 = 16'd200; pin2 = 16'd100; signed_mode = 0; round_mode = 0; Start = 1'b1;
        e.p = 20000; e.s = 0; e.g = 0; e.c = cyc + 1 + 10;
        q.push_back(e);
        @(negedge clk);
        Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            wait_idle();
            pin1 = 16'($urandom) & 16'((1 << $urandom_range(1, 16)) - 1);
            pin2 = 16'($urandom) & 16'((1 << $urandom_range(1, 16)) - 1);
            if ($urandom_range(0, 7) == 0) pin1 = 16'h8000;
            signed_mode = 1'($urandom);
            round_mode = 1'($urandom);
            Start = 1'b1;
            q.push_back(model(pin1, pin2, signed_mode, round_mode, cyc));
            @(negedge clk);
            pin1 = 16'($urandom);
            pin2 = 16'($urandom);
            signed_mode = 1'($urandom);
            round_mode = 1'($urandom);
        end
        Start = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/approximate_multiplier_ext.md
APPROXIMATE_MULTIPLIER_EXT -- requirements
Module: approximate_multiplier_ext

Interface
REQ-001 SHALL have parameter n_input, default 16, meaning operand width in bits.
REQ-002 SHALL have parameter n_effective, default 8, meaning retained significant bits per operand; legal range 2..n_input.
REQ-003 SHALL have localparam SW = $clog2(2*n_input+1), meaning the width of the shift result.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port Start, input, 1, request; sampled only in IDLE.
REQ-007 SHALL have port signed_mode, input, 1: 1 = operands are two's complement; sampled with Start.
REQ-008 SHALL have port round_mode, input, 1: 1 = round-to-nearest on discarded bits, 0 = truncate; sampled with Start.
REQ-009 SHALL have ports pin1 and pin2, input, n_input each, the operands; sampled with Start.
REQ-010 SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port Done, output, 1, a one-cycle pulse that marks valid results.
REQ-012 SHALL have port pout, output, 2*n_effective, the magnitude of the approximate product.
REQ-013 SHALL have port pshift, output, SW, the total right-shift; approximate |product| = pout << pshift.
REQ-014 SHALL have port psign, output, 1, the product sign; 1 = negative.

Function
REQ-015 SHALL implement the FSM IDLE -> NORM -> ROUND -> MULT -> FIN -> IDLE.
REQ-016 IDLE: Start=1 at edge E0 SHALL capture the operands and mode bits and enter NORM.
- In signed mode, operands are replaced by their magnitudes and sign = msb1 XOR msb2.
- In unsigned mode, sign = 0.
REQ-017 NORM: at each edge, every operand whose value is >= 2^n_effective SHALL shift right by 1.
- Its shift count (k1 or k2) SHALL increment.
- The last bit shifted out SHALL be kept as that operand's round bit.
- Once neither operand needs a shift, the next edge SHALL go to ROUND.
- NORM therefore lasts max(k1,k2)+1 cycles; both operands shift in parallel.
REQ-018 ROUND: one cycle, always entered.
- If round_mode=1 and an operand's round bit is 1, that operand SHALL increment.
- If the increment yields 2^n_effective, the operand SHALL become 2^(n_effective-1) and its k SHALL increment.
- If round_mode=0, the operands SHALL be unchanged.
REQ-019 MULT: exactly n_effective cycles of shift-add, LSB-first over operand 2, into a 2*n_effective-bit accumulator.
- No early termination.
REQ-020 FIN: one cycle with Done=1.
- pout, pshift (= k1+k2) and psign SHALL be registered into the outputs on entry to FIN.
- The next edge SHALL return to IDLE.
REQ-021 Done SHALL first be high in the cycle beginning at edge E0 + max(k1,k2) + n_effective + 2, where k1 and k2 are the NORM shift counts before rounding.
REQ-022 psign SHALL be forced to 0 when pout = 0.
REQ-023 pout, pshift and psign SHALL hold their values from the last FIN until the next FIN.
REQ-024 Start SHALL be ignored while Busy=1; no queuing.
- Start held high continuously SHALL cause back-to-back operations, each accepted in IDLE.
REQ-025 For n_effective = n_input, NORM SHALL last 1 cycle, round bits SHALL be 0, and the result SHALL be exact.
REQ-026 A zero operand SHALL give pout = 0 with normal latency.
REQ-027 Signed -2^(n_input-1) SHALL be handled as the unsigned magnitude 2^(n_input-1), with no overflow.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force:
- state IDLE;
- Busy = 0, Done = 0;
- pout = 0, pshift = 0, psign = 0;
- all internal registers to 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation and produce no Done.
REQ-030 Start=1 at the first edge after rst deasserts SHALL be accepted.

Verification (n_input=16, n_effective=8)
REQ-031 Unsigned 200 x 100, truncate -> pout=20000, pshift=0, psign=0; Done at E0+10.
REQ-032 Unsigned 0xFFFF x 3, truncate -> pout=765, pshift=8; Done at E0+18, one cycle wide.
REQ-033 Unsigned 0xFFFF x 3, round -> pout=384, pshift=9; Done at E0+18.
REQ-034 Signed cases:
- 0xFFFE x 0x0005 -> pout=10, pshift=0, psign=1.
- 0x8000 x 0x0001 -> pout=128, pshift=8, psign=1.
- 0x0000 x 0xFFFF -> pout=0, psign=0.
REQ-035 Start toggled during Busy -> ignored, and the first result is unchanged.
- rst pulsed mid-MULT -> all outputs 0 at once, no Done.
- A following Start of 200 x 100 -> the REQ-031 result.
